div32_iterative: RTL

DIV32_ITERATIVE -- requirements
Module: div32_iterative

---
 rtl/div_pkg.sv | 13 +
 rtl/cla_adder_32.sv | 31 +++
 rtl/div_step.sv | 39 +++
 rtl/div32_iterative.sv | 115 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and iteration count.
package div_pkg;

  localparam int unsigned DIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/cla_adder_32.sv
// Carry-propagate adder with subtract mode; cout is the inverted borrow when sub=1.
module cla_adder_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign b_eff = b ^ {WIDTH{sub}};
  assign gen   = a & b_eff;
  assign prop  = a ^ b_eff;

  always_comb begin : carry_chain
    logic c;
    c   = sub;
    sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = prop[i] ^ c;
      c      = gen[i] | (prop[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           no_borrow;
  logic           diff_msb_unused;

  assign shifted = {rem, quo[WIDTH-1]};

  cla_adder_32 #(.WIDTH(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, divisor}),
    .sub  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign diff_msb_unused = diff[WIDTH];

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (no_borrow) begin
      rem_next    = diff[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div32_iterative.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per falling clock edge.
module div32_iterative
  import div_pkg::*;
#(
  parameter int unsigned OPERAND_SIZE = DIV_ITERATIONS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    signed_div_i,
  input  logic [OPERAND_SIZE-1:0] dividend_i,
  input  logic [OPERAND_SIZE-1:0] divisor_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [OPERAND_SIZE-1:0] quotient_o,
  output logic [OPERAND_SIZE-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(OPERAND_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OPERAND_SIZE - 1);
  localparam logic [OPERAND_SIZE-1:0] MIN_NEG = {1'b1, {(OPERAND_SIZE-1){1'b0}}};

  div_state_e              state;
  logic [OPERAND_SIZE-1:0] rem;
  logic [OPERAND_SIZE-1:0] quo;
  logic [OPERAND_SIZE-1:0] dvsr;
  logic [CNT_W-1:0]        cnt;
  logic                    quo_neg;
  logic                    rem_neg;

  logic [OPERAND_SIZE-1:0] rem_next;
  logic [OPERAND_SIZE-1:0] quo_next;
  logic [OPERAND_SIZE-1:0] dividend_abs;
  logic [OPERAND_SIZE-1:0] divisor_abs;
  logic                    div_zero;
  logic                    overflow;

  always_comb begin
    dividend_abs = (signed_div_i && dividend_i[OPERAND_SIZE-1]) ? -dividend_i : dividend_i;
    divisor_abs  = (signed_div_i && divisor_i[OPERAND_SIZE-1])  ? -divisor_i  : divisor_i;
    div_zero     = (divisor_i == '0);
    overflow     = signed_div_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
  end

  div_step #(.WIDTH(OPERAND_SIZE)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign fix-up is folded into the FIX->DONE load so the outputs only ever show final results.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (div_zero) begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              valid_o     <= 1'b1;
              state       <= DONE;
            end else if (overflow) begin
              quotient_o  <= MIN_NEG;
              remainder_o <= '0;
              valid_o     <= 1'b1;
              state       <= DONE;
            end else begin
              rem     <= '0;
              quo     <= dividend_abs;
              dvsr    <= divisor_abs;
              quo_neg <= signed_div_i & (dividend_i[OPERAND_SIZE-1] ^ divisor_i[OPERAND_SIZE-1]);
              rem_neg <= signed_div_i & dividend_i[OPERAND_SIZE-1];
              cnt     <= CNT_LOAD;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient_o  <= quo_neg ? -quo : quo;
          remainder_o <= rem_neg ? -rem : rem;
          valid_o     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
